// File: rtl/gradient_descent_vec_if.sv
// Handshake/data bundle between the gradient path and the weight update unit.
// GRAD_DESCENT_WEIGHT_DECAY_EN adds the wd_in weight-decay coefficient.
interface gradient_descent_vec_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LANES   = 4,
    parameter int unsigned BATCH_W = 16
);
    logic [WIDTH-1:0]       lr_in;
    logic [LANES*WIDTH-1:0] W_old_in;
    logic [LANES*WIDTH-1:0] grad_in;
    logic [BATCH_W-1:0]     batch_len_in;
    logic                   in_valid_in;
    logic                   in_ready_out;
    logic [LANES*WIDTH-1:0] W_updated_out;
    logic [LANES-1:0]       sat_out;
    logic                   out_valid_out;
    logic                   out_ready_in;
    logic                   batch_done_out;
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
    logic [WIDTH-1:0]       wd_in;
`endif

    modport slave (
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
        input  wd_in,
`endif
        input  lr_in, W_old_in, grad_in, batch_len_in, in_valid_in, out_ready_in,
        output in_ready_out, W_updated_out, sat_out, out_valid_out, batch_done_out
    );

    modport master (
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
        output wd_in,
`endif
        output lr_in, W_old_in, grad_in, batch_len_in, in_valid_in, out_ready_in,
        input  in_ready_out, W_updated_out, sat_out, out_valid_out, batch_done_out
    );
endinterface

// File: rtl/gradient_descent_vec.sv
// Vector SGD weight update: W_new = W_old - lr*grad per lane, signed fixed point,
// round-half-up, saturating, with a global-stall valid/ready pipeline and batch tagging.
// Optional GRAD_DESCENT_WEIGHT_DECAY_EN folds wd*W_old into the gradient.
module gradient_descent_vec #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned BATCH_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    gradient_descent_vec_if.slave bus
);
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
    localparam int unsigned GW = WIDTH + 2;
    localparam logic signed [2*WIDTH-1:0] RND_WD = (2*WIDTH)'(2 ** (FRAC - 1));
`else
    localparam int unsigned GW = WIDTH;
`endif
    localparam int unsigned PW = WIDTH + GW;
    localparam logic signed [PW-1:0] RND   = PW'(2 ** (FRAC - 1));
    localparam logic signed [PW:0]   D_MAX = (PW+1)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [PW:0]   D_MIN = ~D_MAX;
    localparam logic [WIDTH-1:0]     W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // S1: accepted beat operands
    logic                   s1_valid_q, s1_last_q;
    logic [WIDTH-1:0]       s1_lr_q;
    logic [LANES*WIDTH-1:0] s1_w_q, s1_g_q;
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
    logic [WIDTH-1:0]       s1_wd_q;
    logic signed [2*WIDTH-1:0] wd_prod [LANES];
    logic signed [2*WIDTH-1:0] wd_term [LANES];
`endif
    // S2: products with the old weights riding alongside
    logic                   s2_valid_q, s2_last_q;
    logic signed [PW-1:0]   s2_p_q [LANES];
    logic [LANES*WIDTH-1:0] s2_w_q;
    // Output register
    logic                   out_valid_q, out_last_q;
    logic [LANES*WIDTH-1:0] out_w_q;
    logic [LANES-1:0]       out_sat_q;
    // Batch tracking
    logic [BATCH_W-1:0]     cnt_q, len_q, len_cur, cnt_next;
    logic                   is_last;

    logic                   adv, accept;
    logic signed [GW-1:0]   g_eff [LANES];
    logic signed [PW-1:0]   p_c [LANES];
    logic signed [PW-1:0]   s_c [LANES];
    logic signed [PW:0]     d_c [LANES];
    logic [LANES*WIDTH-1:0] res_w;
    logic [LANES-1:0]       res_sat;

    assign adv              = !out_valid_q || bus.out_ready_in;
    assign accept           = bus.in_valid_in && adv;
    assign bus.in_ready_out = adv;

    // Batch length is taken only on the first beat; later changes wait for the next batch.
    always_comb begin
        len_cur = len_q;
        if (cnt_q == '0) begin
            len_cur = (bus.batch_len_in == '0) ? BATCH_W'(1) : bus.batch_len_in;
        end
        is_last  = (cnt_q == len_cur - BATCH_W'(1));
        cnt_next = is_last ? '0 : cnt_q + BATCH_W'(1);
    end

    // S1 datapath: effective gradient and full-width product per lane
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            g_eff[i] = GW'($signed(s1_g_q[i*WIDTH +: WIDTH]));
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
            wd_prod[i] = (2*WIDTH)'($signed(s1_wd_q)) *
                         (2*WIDTH)'($signed(s1_w_q[i*WIDTH +: WIDTH]));
            wd_term[i] = (wd_prod[i] + RND_WD) >>> FRAC;
            g_eff[i]   = g_eff[i] + GW'(wd_term[i]);
`endif
            p_c[i] = PW'($signed(s1_lr_q)) * PW'(g_eff[i]);
        end
    end

    // S2 datapath: round, subtract at one extra bit, clamp to the weight range
    always_comb begin
        res_w   = '0;
        res_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            s_c[i] = (s2_p_q[i] + RND) >>> FRAC;
            d_c[i] = (PW+1)'($signed(s2_w_q[i*WIDTH +: WIDTH])) - (PW+1)'(s_c[i]);
            if (d_c[i] > D_MAX) begin
                res_w[i*WIDTH +: WIDTH] = W_MAX;
                res_sat[i]              = 1'b1;
            end else if (d_c[i] < D_MIN) begin
                res_w[i*WIDTH +: WIDTH] = W_MIN;
                res_sat[i]              = 1'b1;
            end else begin
                res_w[i*WIDTH +: WIDTH] = d_c[i][WIDTH-1:0];
            end
        end
    end

    // Pipeline and batch state; everything holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_lr_q     <= '0;
            s1_w_q      <= '0;
            s1_g_q      <= '0;
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
            s1_wd_q     <= '0;
`endif
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_w_q      <= '0;
            for (int i = 0; i < LANES; i++) s2_p_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_w_q     <= '0;
            out_sat_q   <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
        end else if (adv) begin
            s1_valid_q <= accept;
            // Bubbles carry no last tag so batch_done never fires on them
            s1_last_q  <= accept && is_last;
            if (accept) begin
                s1_lr_q <= bus.lr_in;
                s1_w_q  <= bus.W_old_in;
                s1_g_q  <= bus.grad_in;
`ifdef GRAD_DESCENT_WEIGHT_DECAY_EN
                s1_wd_q <= bus.wd_in;
`endif
                cnt_q   <= cnt_next;
                if (cnt_q == '0) len_q <= len_cur;
            end
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            s2_w_q      <= s1_w_q;
            s2_p_q      <= p_c;
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_last_q;
            out_w_q     <= res_w;
            out_sat_q   <= res_sat;
        end
    end

    assign bus.out_valid_out  = out_valid_q;
    assign bus.W_updated_out  = out_w_q;
    assign bus.sat_out        = out_sat_q;
    assign bus.batch_done_out = out_last_q;
endmodule
